// File: rtl/serial_adder_4bit_if.sv
// -----------------------------------------------------------------------------
// serial_adder_4bit_if
// Bundle of the start/done handshake and operand/result bus of the bit-serial
// adder.
//   master : drives start, A, B, CIN; observes busy, done, SUM, COUT (, OVF)
//   slave  : the adder itself; the mirror image of master
// Optional macro SERIAL_ADDER_OVF_EN adds the registered signed-overflow flag OVF.
// -----------------------------------------------------------------------------
interface serial_adder_4bit_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
`ifdef SERIAL_ADDER_OVF_EN
    logic             OVF;

    modport master (
        output start, A, B, CIN,
        input  busy, done, SUM, COUT, OVF
    );

    modport slave (
        input  start, A, B, CIN,
        output busy, done, SUM, COUT, OVF
    );
`else
    modport master (
        output start, A, B, CIN,
        input  busy, done, SUM, COUT
    );

    modport slave (
        input  start, A, B, CIN,
        output busy, done, SUM, COUT
    );
`endif
endinterface

// File: rtl/serial_adder_4bit.sv
// -----------------------------------------------------------------------------
// serial_adder_4bit
// Bit-serial adder: SUM = A + B + CIN, one bit per clock, LSB first.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - serial_adder_4bit_if.slave:
//          start/A/B/CIN in (sampled only on the accepting edge),
//          busy/done/SUM/COUT out (all registered)
// Optional macro SERIAL_ADDER_OVF_EN: adds bus.OVF, the registered signed
// two's-complement overflow, updated together with SUM/COUT.
// Latency: start accepted at edge 0, bits processed at edges 1..WIDTH, done and
// the new result visible after edge WIDTH. A start during the DONE cycle is
// accepted immediately (back-to-back, no bubble).
// -----------------------------------------------------------------------------
module serial_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_adder_4bit_if.slave    bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Carry of a full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             bit_sum;
    logic             bit_carry;
    // Partial sum with the new bit prepended; bits [WIDTH:1] are the right-shifted
    // result, which also works for WIDTH=1.
    logic [WIDTH:0]   psum_ext;
    logic             last_bit;

    // Next-state and datapath computation for the serial addition.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        carry_d  = carry_q;
        psum_d   = psum_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        bit_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        bit_carry = maj3(a_sr_q[0], b_sr_q[0], carry_q);
        psum_ext  = {bit_sum, psum_q};
        last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                    a_sr_d  = bus.A;
                    b_sr_d  = bus.B;
                    carry_d = bus.CIN;
                    psum_d  = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                psum_d  = psum_ext[WIDTH:1];
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = bit_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = ST_DONE;
                    sum_d   = psum_ext[WIDTH:1];
                    cout_d  = bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on the final bit.
                    ovf_d   = carry_q ^ bit_carry;
`endif
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= {WIDTH{1'b0}};
            b_sr_q  <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            psum_q  <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            psum_q  <= psum_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.SUM  = sum_q;
    assign bus.COUT = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_4bit.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_4bit
// Directed vectors with hand-computed results pushed into a scoreboard queue;
// an independent monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_serial_adder_4bit;

    localparam int W = 4;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;

    serial_adder_4bit_if #(.WIDTH(W)) bus ();

    serial_adder_4bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units period.
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst === 1'b0 && bus.done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual SUM=%0h required no done", bus.SUM);
            end else begin
                e = exp_q.pop_front();
                check("sum", int'(bus.SUM), int'(e.sum));
                check("cout", int'(bus.COUT), int'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", int'(bus.OVF), int'(e.ovf));
`endif
            end
        end
    end

    // Present one request for exactly one edge; returns at the first busy cycle.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input exp_t e, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.CIN   = cin;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.CIN   = ~cin;
    endtask

    // Count busy cycles until done is seen; bounded.
    task automatic wait_done(output int busy_n);
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) return;
            if (bus.busy === 1'b1) busy_n++;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL done_timeout actual no done required done within 20 cycles");
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        exp_t       e;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        int ds;

        //               A      B      CIN    SUM    COUT  OVF
        vecs[0] = '{4'h3, 4'h2, 1'b0, '{4'h5, 1'b0, 1'b0}};
        vecs[1] = '{4'h1, 4'h7, 1'b0, '{4'h8, 1'b0, 1'b1}};
        vecs[2] = '{4'hF, 4'h1, 1'b0, '{4'h0, 1'b1, 1'b0}};
        vecs[3] = '{4'h0, 4'h0, 1'b1, '{4'h1, 1'b0, 1'b0}};
        vecs[4] = '{4'hF, 4'hF, 1'b1, '{4'hF, 1'b1, 1'b0}};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = 4'h0;
        bus.B     = 4'h0;
        bus.CIN   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_sum", int'(bus.SUM), 0);
        check("rst_cout", int'(bus.COUT), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed arithmetic vectors with latency and pulse-width checks.
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].e, 1'b1);
            wait_done(n);
            check("busy_cycles", n, 4);
            @(negedge clk);
            check("done_pulse", int'(bus.done), 0);
            check("idle_after_done", int'(bus.busy), 0);
        end
        check("done_count_vectors", done_seen, 5);

        // start during SHIFT with changed A is ignored.
        ds = done_seen;
        issue(4'h3, 4'h2, 1'b0, '{4'h5, 1'b0, 1'b0}, 1'b1);
        @(negedge clk);
        bus.A     = 4'hF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 4'h0;
        wait_done(n);
        check("ignore_start_latency", n, 2);
        @(negedge clk);
        check("ignore_done_pulse", int'(bus.done), 0);
        repeat (6) @(negedge clk);
        check("ignore_single_done", done_seen - ds, 1);

        // Back-to-back: start held through the DONE cycle.
        issue(4'h3, 4'h2, 1'b0, '{4'h5, 1'b0, 1'b0}, 1'b1);
        wait_done(n);
        bus.start = 1'b1;
        bus.A     = 4'h4;
        bus.B     = 4'h4;
        bus.CIN   = 1'b0;
        exp_q.push_back('{4'h8, 1'b0, 1'b1});
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_no_bubble", int'(bus.busy), 1);
        check("b2b_sum_hold", int'(bus.SUM), 5);
        wait_done(n);
        check("b2b_busy_cycles", n, 4);
        @(negedge clk);
        check("b2b_done_pulse", int'(bus.done), 0);

        // Reset two cycles into an operation aborts it immediately.
        issue(4'h3, 4'h2, 1'b0, '{4'h5, 1'b0, 1'b0}, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_sum", int'(bus.SUM), 0);
        check("abort_cout", int'(bus.COUT), 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("abort_ovf", int'(bus.OVF), 0);
`endif
        ds = done_seen;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_done", done_seen - ds, 0);

        issue(4'hF, 4'h1, 1'b0, '{4'h0, 1'b1, 1'b0}, 1'b1);
        wait_done(n);
        check("post_reset_busy_cycles", n, 4);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
